ysyx_25040105_ifu: RTL and testbench

Instruction fetch unit: owns the PC and issues one outstanding word read at a time to instruction memory. It buffers the returned word and presents it, with its PC, to the decode stage over a valid/ready handshake. Taken branches and jumps from execute redirect it. It is the producer end of the `inst` interface consumed by the IDU.

---
 rtl/ysyx_25040105_ifu.sv | 107 ++++++++++
 tb/tb_ysyx_25040105_ifu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: owns the PC, keeps one word read in flight to imem,
// and hands the buffered instruction to decode over a valid/ready handshake.
module ysyx_25040105_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DROP
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_nxt, inst_pc_nxt;
   logic [31:0] redirect_tgt;

   // Redirect targets are word aligned; the low two bits are simply cleared.
   assign redirect_tgt = redirect_pc & ~32'h3;

   // NOTE: every variable assigned in this block gets its hold value first,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      inst_nxt    = inst;
      inst_pc_nxt = inst_pc;
      unique case (state)
         IDLE: begin
            state_nxt = REQ;
            if (redirect_valid) pc_nxt = redirect_tgt;
         end
         REQ: begin
            if (redirect_valid) pc_nxt = redirect_tgt;
            // A redirect racing the accept leaves a wrong-path read in flight.
            if (imem_req_ready) state_nxt = redirect_valid ? DROP : WAIT;
         end
         WAIT: begin
            if (imem_resp_valid) begin
               if (redirect_valid) begin
                  pc_nxt    = redirect_tgt;
                  state_nxt = REQ;
               end else begin
                  inst_nxt    = imem_resp_data;
                  inst_pc_nxt = pc;
                  state_nxt   = HOLD;
               end
            end else if (redirect_valid) begin
               pc_nxt    = redirect_tgt;
               state_nxt = DROP;
            end
         end
         HOLD: begin
            // Redirect takes priority over a same-cycle decode handshake.
            if (redirect_valid) begin
               pc_nxt    = redirect_tgt;
               state_nxt = REQ;
            end else if (inst_ready) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = REQ;
            end
         end
         DROP: begin
            if (redirect_valid) pc_nxt = redirect_tgt;
            if (imem_resp_valid) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         inst    <= '0;
         inst_pc <= '0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         inst    <= inst_nxt;
         inst_pc <= inst_pc_nxt;
      end
   end

   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;
   assign inst_valid     = (state == HOLD);

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Self-checking bench for ysyx_25040105_ifu: directed scenarios followed by
// random traffic, all compared against a transaction-level fetch model.
module tb_ysyx_25040105_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   always #5 clk = ~clk;

   ysyx_25040105_ifu #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: fetch progress as flags rather than a state machine.
   bit          m_started;   // first cycle after reset has elapsed
   bit          m_busy;      // a read is in flight
   bit          m_stale;     // the in-flight read is wrong-path
   bit          m_hold;      // an instruction is offered to decode
   logic [31:0] m_pc, m_inst, m_inst_pc;

   // Instruction memory model: one pending read with a programmable latency.
   bit          mem_ready_en;
   bit          mem_pending;
   int          mem_cnt;
   int          mem_lat;
   logic [31:0] mem_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h0010_0093;
      return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0;
      m_busy    = 0;
      m_stale   = 0;
      m_hold    = 0;
      m_pc      = RESET_PC;
      m_inst    = '0;
      m_inst_pc = '0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      tgt = {redirect_pc[31:2], 2'b00};
      if (rst) begin
         model_reset();
      end else if (!m_started) begin
         m_started = 1;
         if (redirect_valid) m_pc = tgt;
      end else if (m_hold) begin
         if (redirect_valid) begin
            m_pc = tgt;  m_hold = 0;
         end else if (inst_ready) begin
            m_pc = m_pc + 4;  m_hold = 0;
         end
      end else if (!m_busy) begin
         if (imem_req_ready) begin
            m_busy  = 1;
            m_stale = redirect_valid;
         end
         if (redirect_valid) m_pc = tgt;
      end else if (m_stale) begin
         if (imem_resp_valid) begin
            m_busy = 0;  m_stale = 0;
         end
         if (redirect_valid) m_pc = tgt;
      end else begin
         if (imem_resp_valid) begin
            m_busy = 0;
            if (redirect_valid) m_pc = tgt;
            else begin
               m_hold = 1;  m_inst = imem_resp_data;  m_inst_pc = m_pc;
            end
         end else if (redirect_valid) begin
            m_pc = tgt;  m_stale = 1;
         end
      end
   endtask

   task automatic check_model();
      check("req_valid", imem_req_valid, m_started && !m_busy && !m_hold);
      check("req_addr", imem_req_addr, m_pc);
      check("inst_valid", inst_valid, m_hold);
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_inst_pc);
   endtask

   // One clock cycle: drive memory inputs, step both models, check at negedge.
   task automatic tick();
      logic        s_req_v;
      logic [31:0] s_addr;
      imem_req_ready  = mem_ready_en && !mem_pending;
      imem_resp_valid = mem_pending && (mem_cnt == 0);
      imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      s_req_v = imem_req_valid;
      s_addr  = imem_req_addr;
      @(posedge clk);
      model_step();
      if (imem_resp_valid) mem_pending = 0;
      else if (mem_pending && mem_cnt > 0) mem_cnt--;
      if (s_req_v && imem_req_ready) begin
         mem_pending = 1;  mem_addr = s_addr;  mem_cnt = mem_lat;
      end
      @(negedge clk);
      redirect_valid = 0;
      check_model();
   endtask

   task automatic wait_inst(input string tag, input int budget);
      int n = 0;
      while (!inst_valid && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_inst_valid"}, inst_valid, 1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (!imem_req_valid && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_req_valid"}, imem_req_valid, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_valid"}, imem_req_valid, 0);
      check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
      check({tag, "_inst_valid"}, inst_valid, 0);
      check({tag, "_inst"}, inst, 0);
      check({tag, "_inst_pc"}, inst_pc, 0);
   endtask

   initial begin
      rst = 1;  redirect_valid = 0;  redirect_pc = '0;  inst_ready = 0;
      imem_req_ready = 0;  imem_resp_valid = 0;  imem_resp_data = '0;
      mem_ready_en = 1;  mem_pending = 0;  mem_cnt = 0;  mem_lat = 0;  mem_addr = '0;
      model_reset();

      // Reset and first fetch with a single-cycle memory.
      @(negedge clk);
      check_reset_values("reset");
      tick();
      rst = 0;
      check("idle_no_req", imem_req_valid, 0);
      tick();
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, 32'h8000_0000);
      tick();
      tick();
      check("first_inst_valid", inst_valid, 1);
      check("first_inst", inst, 32'h0010_0093);
      check("first_inst_pc", inst_pc, 32'h8000_0000);

      // Decode backpressure: the held word stays put and no request is issued.
      repeat (5) begin
         tick();
         check("bp_inst", inst, 32'h0010_0093);
         check("bp_inst_pc", inst_pc, 32'h8000_0000);
         check("bp_no_req", imem_req_valid, 0);
      end
      inst_ready = 1;
      tick();
      inst_ready = 0;
      check("next_req_valid", imem_req_valid, 1);
      check("next_req_addr", imem_req_addr, 32'h8000_0004);
      tick();
      check("single_req", imem_req_valid, 0);
      tick();
      inst_ready = 1;
      mem_lat = 3;
      tick();
      inst_ready = 0;
      check("req_at_8", imem_req_addr, 32'h8000_0008);

      // Redirect while the read of 0x8000_0008 is still pending.
      tick();
      redirect_valid = 1;  redirect_pc = 32'h8000_0100;
      tick();
      check("drop_addr", imem_req_addr, 32'h8000_0100);
      check("drop_no_req", imem_req_valid, 0);
      wait_req("drop_done", 10);
      check("drop_req_addr", imem_req_addr, 32'h8000_0100);
      mem_lat = 0;
      wait_inst("redir_wait", 10);
      check("redir_wait_pc", inst_pc, 32'h8000_0100);
      check("redir_wait_inst", inst, mem_word(32'h8000_0100));

      // Redirect and decode handshake together in HOLD.
      redirect_valid = 1;  redirect_pc = 32'h8000_0010;
      tick();
      wait_inst("hold_at_10", 10);
      check("hold_at_10_pc", inst_pc, 32'h8000_0010);
      redirect_valid = 1;  redirect_pc = 32'h8000_0040;  inst_ready = 1;
      tick();
      inst_ready = 0;
      check("redir_wins_addr", imem_req_addr, 32'h8000_0040);
      check("redir_wins_valid", imem_req_valid, 1);

      // Memory stall, then a misaligned redirect while still requesting.
      mem_ready_en = 0;
      repeat (4) begin
         tick();
         check("stall_valid", imem_req_valid, 1);
         check("stall_addr", imem_req_addr, 32'h8000_0040);
      end
      redirect_valid = 1;  redirect_pc = 32'h8000_0023;
      tick();
      check("stall_redir_addr", imem_req_addr, 32'h8000_0020);
      check("stall_redir_valid", imem_req_valid, 1);

      // Asynchronous reset while a read is in flight.
      mem_ready_en = 1;  mem_lat = 3;
      tick();
      tick();
      rst = 1;
      #1;
      model_reset();
      check_reset_values("async_reset");
      tick();
      rst = 0;
      check("restart_idle", imem_req_valid, 0);
      tick();
      check("restart_req_valid", imem_req_valid, 1);
      check("restart_req_addr", imem_req_addr, RESET_PC);
      wait_inst("restart", 30);
      check("restart_inst_pc", inst_pc, RESET_PC);
      check("restart_inst", inst, 32'h0010_0093);

      // PC wraps modulo 2^32.
      mem_lat = 0;
      redirect_valid = 1;  redirect_pc = 32'hFFFF_FFFC;
      tick();
      wait_inst("wrap", 10);
      check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      inst_ready = 1;
      tick();
      inst_ready = 0;
      check("wrap_addr", imem_req_addr, 32'h0000_0000);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         mem_ready_en = ($urandom_range(0, 3) != 0);
         mem_lat      = $urandom_range(0, 3);
         inst_ready   = $urandom_range(0, 1);
         if ($urandom_range(0, 9) == 0) begin
            redirect_valid = 1;
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : $urandom;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
